// File: rtl/rx_sample_ring_sweeper.sv
// rtl/rx_sample_ring_sweeper.sv - circular receiver sample history with per-write oldest-to-newest sweep
//
// Stores accepted samples in a DEPTH-entry ring held in a simple dual-port RAM.
// Every accepted write triggers a full replay of the valid history, oldest
// first, framed with rd_first/rd_last. A write that arrives while a sweep is
// still running abandons it and raises overrun.
//
// Ports:
//   crx_clk     receiver clock, rising edge
//   rrx_rst_n   asynchronous active-low reset
//   erx_en      block enable; low ignores writes and aborts a sweep quietly
//   wr_en       new-sample strobe, wr_data the sample
//   rd_data     swept sample, rd_valid qualifies it
//   rd_first    oldest sample of a sweep, rd_last newest (just-written) sample
//   busy        sweep issuing addresses or draining the last read
//   fill_count  number of valid samples, saturating at DEPTH; full at DEPTH
//   overrun     one-cycle pulse when a write aborts a sweep
module rx_sample_ring_sweeper #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 510,
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 10
) (
    input  logic              crx_clk,
    input  logic              rrx_rst_n,
    input  logic              erx_en,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_first,
    output logic              rd_last,
    output logic              busy,
    output logic [CNT_W-1:0]  fill_count,
    output logic              full,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  ONE_CNT   = CNT_W'(1);
    localparam int                SUB_W     = ((ADDR_W > CNT_W) ? ADDR_W : CNT_W) + 1;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_e;

    logic [DATA_W-1:0] mem [DEPTH];

    state_e            state_q;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_inc;
    logic [CNT_W-1:0]  rem_q;
    logic [CNT_W-1:0]  fill_q, fill_d;
    logic              first_pend_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q, rd_first_q, rd_last_q;
    logic              busy_q, full_q, overrun_q;

    logic              wr_acc;
    logic [SUB_W-1:0]  wp_ext, fn_ext, oldest_ext;
    logic [ADDR_W-1:0] oldest_addr;

    assign wr_acc     = erx_en & wr_en;
    assign wr_ptr_d   = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + ADDR_W'(1);
    assign rd_ptr_inc = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + ADDR_W'(1);
    assign fill_d     = (fill_q == DEPTH_CNT) ? fill_q : fill_q + ONE_CNT;

    // Oldest valid address = (wr_ptr_d - fill_d) mod DEPTH. Computed one bit
    // wider than either operand so the +DEPTH correction never overflows,
    // which keeps it correct for non-power-of-two depths.
    always_comb begin
        wp_ext     = SUB_W'(wr_ptr_d);
        fn_ext     = SUB_W'(fill_d);
        oldest_ext = (wp_ext >= fn_ext) ? (wp_ext - fn_ext)
                                        : (wp_ext + SUB_W'(DEPTH) - fn_ext);
        oldest_addr = ADDR_W'(oldest_ext);
    end

    // RAM write port; contents are never reset, fill_count defines validity.
    always_ff @(posedge crx_clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
        if (!rrx_rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rem_q        <= '0;
            fill_q       <= '0;
            first_pend_q <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            rd_first_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            busy_q       <= 1'b0;
            full_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            // Read port runs every cycle; rd_valid decides whether it counts.
            rd_data_q  <= mem[rd_ptr_q];
            rd_valid_q <= 1'b0;
            rd_first_q <= 1'b0;
            rd_last_q  <= 1'b0;
            overrun_q  <= 1'b0;
            if (!erx_en) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else if (wr_en) begin
                // A write always restarts the sweep, so the read issued this
                // cycle is dropped and no read can collide with the write.
                wr_ptr_q     <= wr_ptr_d;
                fill_q       <= fill_d;
                full_q       <= (fill_d == DEPTH_CNT);
                overrun_q    <= (state_q != IDLE);
                rd_ptr_q     <= oldest_addr;
                rem_q        <= fill_d;
                first_pend_q <= 1'b1;
                state_q      <= SWEEP;
                busy_q       <= 1'b1;
            end else begin
                case (state_q)
                    SWEEP: begin
                        rd_valid_q   <= 1'b1;
                        rd_first_q   <= first_pend_q;
                        rd_last_q    <= (rem_q == ONE_CNT);
                        first_pend_q <= 1'b0;
                        rd_ptr_q     <= rd_ptr_inc;
                        rem_q        <= rem_q - ONE_CNT;
                        if (rem_q == ONE_CNT) begin
                            state_q <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign rd_first   = rd_first_q;
    assign rd_last    = rd_last_q;
    assign busy       = busy_q;
    assign fill_count = fill_q;
    assign full       = full_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_rx_sample_ring_sweeper.sv
// tb/tb_rx_sample_ring_sweeper.sv - self-checking bench for rx_sample_ring_sweeper
module tb_rx_sample_ring_sweeper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] wdata = '0;

    logic [15:0] o_data [2];
    logic        o_valid [2];
    logic        o_first [2];
    logic        o_last [2];
    logic        o_busy [2];
    logic        o_full [2];
    logic        o_ovr [2];
    logic [3:0]  a_fill;
    logic [9:0]  b_fill;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rx_sample_ring_sweeper #(.DATA_W(16), .DEPTH(8), .ADDR_W(3), .CNT_W(4)) u_a (
        .crx_clk(clk), .rrx_rst_n(rst_n), .erx_en(en), .wr_en(wr), .wr_data(wdata),
        .rd_data(o_data[0]), .rd_valid(o_valid[0]), .rd_first(o_first[0]), .rd_last(o_last[0]),
        .busy(o_busy[0]), .fill_count(a_fill), .full(o_full[0]), .overrun(o_ovr[0])
    );

    rx_sample_ring_sweeper #(.DATA_W(16), .DEPTH(510), .ADDR_W(9), .CNT_W(10)) u_b (
        .crx_clk(clk), .rrx_rst_n(rst_n), .erx_en(en), .wr_en(wr), .wr_data(wdata),
        .rd_data(o_data[1]), .rd_valid(o_valid[1]), .rd_first(o_first[1]), .rd_last(o_last[1]),
        .busy(o_busy[1]), .fill_count(b_fill), .full(o_full[1]), .overrun(o_ovr[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: the log of accepted samples since reset, plus for each
    // instance the edge index at which the current sweep started and its length.
    int wlog[$];
    int dep[2] = '{8, 510};
    bit act[2];
    int st[2];
    int fl[2];
    bit ovr_e[2];
    int cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            wlog.delete();
            for (int i = 0; i < 2; i++) begin act[i] = 0; ovr_e[i] = 0; end
        end else if (!en) begin
            for (int i = 0; i < 2; i++) begin act[i] = 0; ovr_e[i] = 0; end
        end else if (wr) begin
            wlog.push_back(int'(wdata));
            for (int i = 0; i < 2; i++) begin
                ovr_e[i] = act[i] && (cyc - 1 <= st[i] + fl[i]);
                fl[i]    = (wlog.size() < dep[i]) ? wlog.size() : dep[i];
                st[i]    = cyc;
                act[i]   = 1;
            end
        end else begin
            for (int i = 0; i < 2; i++) ovr_e[i] = 0;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            int n, fexp, idx, fillv;
            bit vexp, bexp;
            n     = wlog.size();
            fexp  = (n < dep[i]) ? n : dep[i];
            fillv = (i == 0) ? int'(a_fill) : int'(b_fill);
            bexp  = act[i] && (cyc <= st[i] + fl[i]);
            vexp  = act[i] && (cyc >= st[i] + 1) && (cyc <= st[i] + fl[i]);
            chk($sformatf("rd_valid_%0d", i), int'(o_valid[i]), int'(vexp));
            chk($sformatf("busy_%0d", i), int'(o_busy[i]), int'(bexp));
            chk($sformatf("fill_%0d", i), fillv, fexp);
            chk($sformatf("full_%0d", i), int'(o_full[i]), int'(fexp == dep[i]));
            chk($sformatf("overrun_%0d", i), int'(o_ovr[i]), int'(ovr_e[i]));
            if (!rst_n) chk($sformatf("rst_data_%0d", i), int'(o_data[i]), 0);
            if (vexp) begin
                idx = cyc - st[i] - 1;
                chk($sformatf("rd_data_%0d", i), int'(o_data[i]), wlog[n - fl[i] + idx]);
                chk($sformatf("rd_first_%0d", i), int'(o_first[i]), int'(idx == 0));
                chk($sformatf("rd_last_%0d", i), int'(o_last[i]), int'(idx == fl[i] - 1));
            end
        end
    end

    task automatic do_write(input int v);
        @(negedge clk);
        wr = 1'b1;
        wdata = 16'(v);
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int lit3[3] = '{10, 20, 30};
        int lit_ab[8] = '{5, 6, 7, 8, 9, 10, 100, 101};
        int ov, nv, lastpos, fdat, ldat;
        bit sawlast;

        idle(3);
        chk("reset_valid", int'(o_valid[0]), 0);
        chk("reset_fill", int'(a_fill), 0);
        chk("reset_busy", int'(o_busy[0]), 0);
        rst_n = 1'b1;
        en = 1'b1;

        // Basic fill
        do_write(10); idle(12);
        do_write(20); idle(12);
        do_write(30);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("basic_valid", int'(o_valid[0]), 1);
            chk("basic_data", int'(o_data[0]), lit3[k]);
            chk("basic_first", int'(o_first[0]), int'(k == 0));
            chk("basic_last", int'(o_last[0]), int'(k == 2));
        end
        chk("basic_fill", int'(a_fill), 3);
        chk("basic_full", int'(o_full[0]), 0);
        @(negedge clk);
        chk("basic_end_valid", int'(o_valid[0]), 0);
        idle(4);

        // Wrap
        for (int v = 1; v <= 10; v++) begin
            do_write(v);
            if (v != 10) idle(10);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("wrap_data", int'(o_data[0]), 3 + k);
            chk("wrap_first", int'(o_first[0]), int'(k == 0));
            chk("wrap_last", int'(o_last[0]), int'(k == 7));
        end
        chk("wrap_fill", int'(a_fill), 8);
        chk("wrap_full", int'(o_full[0]), 1);
        idle(4);

        // Abort
        do_write(100);
        idle(2);
        chk("abort_nolast", int'(o_last[0]), 0);
        do_write(101);
        chk("abort_overrun", int'(o_ovr[0]), 1);
        chk("abort_valid_drop", int'(o_valid[0]), 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) chk("abort_ovr_pulse", int'(o_ovr[0]), 0);
            chk("abort_data", int'(o_data[0]), lit_ab[k]);
            chk("abort_last", int'(o_last[0]), int'(k == 7));
        end
        idle(3);

        // Enable low mid-sweep
        do_write(55);
        idle(2);
        @(negedge clk);
        en = 1'b0; wr = 1'b1; wdata = 16'd77;
        @(negedge clk);
        chk("en_valid", int'(o_valid[0]), 0);
        chk("en_overrun", int'(o_ovr[0]), 0);
        chk("en_busy", int'(o_busy[0]), 0);
        idle(3);
        chk("en_fill", int'(a_fill), 8);
        wr = 1'b0; en = 1'b1;
        idle(2);

        // Asynchronous reset mid-sweep
        do_write(5);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_data", int'(o_data[0]), 0);
        chk("arst_valid", int'(o_valid[0]), 0);
        chk("arst_busy", int'(o_busy[0]), 0);
        chk("arst_fill", int'(a_fill), 0);
        chk("arst_full", int'(o_full[0]), 0);
        chk("arst_b_fill", int'(b_fill), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_write(7);
        @(negedge clk);
        chk("one_valid", int'(o_valid[0]), 1);
        chk("one_first", int'(o_first[0]), 1);
        chk("one_last", int'(o_last[0]), 1);
        chk("one_data", int'(o_data[0]), 7);
        idle(3);

        // Burst of back-to-back writes
        ov = 0; sawlast = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i > 0) begin ov += int'(o_ovr[0]); sawlast |= o_last[0]; end
            wr = 1'b1;
            wdata = 16'($urandom);
        end
        @(negedge clk);
        ov += int'(o_ovr[0]); sawlast |= o_last[0];
        wr = 1'b0;
        chk("burst_overruns", ov, 19);
        chk("burst_nolast", int'(sawlast), 0);
        nv = 0; lastpos = -1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (o_valid[0]) nv++;
            if (o_valid[0] && o_last[0]) lastpos = k;
        end
        chk("burst_sweep_len", nv, 8);
        chk("burst_last_pos", lastpos, 7);

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            en = ($urandom_range(0, 15) != 0);
            wr = ($urandom_range(0, 3) == 0);
            wdata = 16'($urandom);
        end
        @(negedge clk);
        wr = 1'b0; en = 1'b1;
        idle(3);

        // Non-power-of-two depth
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 515; i++) begin
            @(negedge clk);
            wr = 1'b1;
            wdata = 16'(i);
        end
        @(negedge clk);
        wr = 1'b0;
        nv = 0; fdat = -1; ldat = -1;
        for (int k = 0; k < 512; k++) begin
            @(negedge clk);
            if (o_valid[1]) nv++;
            if (o_valid[1] && o_first[1]) fdat = int'(o_data[1]);
            if (o_valid[1] && o_last[1]) ldat = int'(o_data[1]);
        end
        chk("np2_count", nv, 510);
        chk("np2_first", fdat, 5);
        chk("np2_last", ldat, 514);
        chk("np2_fill", int'(b_fill), 510);
        chk("np2_full", int'(o_full[1]), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
